// File: rtl/inst_loader_if.sv
// Byte-stream and instruction-RAM write bundle for inst_loader.
// master: byte source / RAM-side harness.  slave: the loader itself.
interface inst_loader_if;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;

  modport master (
    output s_data, s_valid,
    input  s_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  s_data, s_valid,
    output s_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/inst_loader.sv
// inst_loader: assembles a length-prefixed little-endian byte stream into
// 32-bit instruction words, writes them to instruction RAM and releases
// the CPU reset once a complete image has landed.
// Optional trailing checksum byte: define INST_LOADER_CSUM_EN.
module inst_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  inst_loader_if.slave bus,
  output logic         cpu_rst_n,
  output logic         busy,
  output logic         done,
  output logic         err
);

  // Largest legal word count; images longer than the RAM are rejected.
  localparam logic [31:0] DEPTH = 32'h0000_0001 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
`ifdef INST_LOADER_CSUM_EN
    , S_CSUM = 3'd7
`endif
  } state_t;

  state_t      state;
  logic [7:0]  len_lo_r;   // low byte of the word count
  logic [15:0] rem_r;      // words still to be written
  logic [1:0]  idx_r;      // lane of the next data byte
  logic [23:0] word_r;     // lanes 0..2 of the word being assembled
  logic        accept_s;
  logic [15:0] count_s;

`ifdef INST_LOADER_CSUM_EN
  logic [7:0]  csum_r;     // running XOR of all data bytes

  function automatic logic [7:0] xor_acc(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  assign accept_s = bus.s_valid & bus.s_ready;
  assign count_s  = {bus.s_data, len_lo_r};

  // Loader FSM; every output is registered and updated on its transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      bus.s_ready  <= 1'b0;
      bus.im_we    <= 1'b0;
      bus.im_addr  <= BASE_ADDR;
      bus.im_wdata <= 32'h0000_0000;
      cpu_rst_n    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      rem_r        <= 16'h0000;
      idx_r        <= 2'd0;
      len_lo_r     <= 8'h00;
      word_r       <= 24'h00_0000;
`ifdef INST_LOADER_CSUM_EN
      csum_r       <= 8'h00;
`endif
    end else begin
      // Write strobe is a single-cycle pulse raised only on entry to WRITE.
      bus.im_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state       <= S_LEN0;
            bus.s_ready <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
            cpu_rst_n   <= 1'b0;
            bus.im_addr <= BASE_ADDR;
            idx_r       <= 2'd0;
`ifdef INST_LOADER_CSUM_EN
            csum_r      <= 8'h00;
`endif
          end
        end
        S_LEN0: begin
          if (accept_s) begin
            len_lo_r <= bus.s_data;
            state    <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (accept_s) begin
            if (count_s == 16'h0000) begin
`ifdef INST_LOADER_CSUM_EN
              state       <= S_CSUM;
`else
              state       <= S_DONE;
              bus.s_ready <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
              cpu_rst_n   <= 1'b1;
`endif
            end else if ({16'h0000, count_s} > DEPTH) begin
              state       <= S_ERR;
              bus.s_ready <= 1'b0;
              busy        <= 1'b0;
              err         <= 1'b1;
            end else begin
              state <= S_DATA;
              rem_r <= count_s;
            end
          end
        end
        S_DATA: begin
          if (accept_s) begin
`ifdef INST_LOADER_CSUM_EN
            csum_r <= xor_acc(csum_r, bus.s_data);
`endif
            case (idx_r)
              2'd0:    word_r[7:0]   <= bus.s_data;
              2'd1:    word_r[15:8]  <= bus.s_data;
              2'd2:    word_r[23:16] <= bus.s_data;
              default: begin
                bus.im_wdata <= {bus.s_data, word_r};
                bus.im_we    <= 1'b1;
                bus.s_ready  <= 1'b0;
                state        <= S_WRITE;
              end
            endcase
            idx_r <= idx_r + 2'd1;
          end
        end
        S_WRITE: begin
          bus.im_addr <= bus.im_addr + 32'd4;
          rem_r       <= rem_r - 16'd1;
          if (rem_r == 16'd1) begin
`ifdef INST_LOADER_CSUM_EN
            state       <= S_CSUM;
            bus.s_ready <= 1'b1;
`else
            state       <= S_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            cpu_rst_n   <= 1'b1;
`endif
          end else begin
            state       <= S_DATA;
            bus.s_ready <= 1'b1;
          end
        end
`ifdef INST_LOADER_CSUM_EN
        S_CSUM: begin
          if (accept_s) begin
            bus.s_ready <= 1'b0;
            busy        <= 1'b0;
            if (bus.s_data == csum_r) begin
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_rst_n <= 1'b1;
            end else begin
              state     <= S_ERR;
              err       <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state       <= S_IDLE;
          bus.s_ready <= 1'b0;
          cpu_rst_n   <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
          err         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: table of image scenarios, random
// images checked against a byte-level model, and hand-written corner cases.
module tb_inst_loader;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst, start;
  logic cpu_rst_n, busy, done, err;

  always #5 clk = ~clk;

  inst_loader_if bus_if ();

  inst_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus_if.slave),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_we_cyc = 0;
  int bad_we = 0;
  logic [31:0] w_addr[$];
  logic [31:0] w_data[$];
  logic [7:0]  img[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every RAM write; a write while a byte can be accepted is illegal.
  always @(negedge clk) begin
    if (bus_if.im_we === 1'b1) begin
      w_addr.push_back(bus_if.im_addr);
      w_data.push_back(bus_if.im_wdata);
      last_we_cyc = cyc;
      if (bus_if.s_ready !== 1'b0) bad_we = bad_we + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected word j: little-endian assembly of the image's data bytes.
  function automatic logic [31:0] model_word(input int j);
    int k;
    k = 2 + 4 * j;
    return 32'(img[k]) | (32'(img[k+1]) << 8) | (32'(img[k+2]) << 16) | (32'(img[k+3]) << 24);
  endfunction

  function automatic void add_csum();
`ifdef INST_LOADER_CSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int k = 2; k < img.size(); k++) x = x ^ img[k];
    img.push_back(x);
`endif
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: valid held, 1: valid toggles, 2: random valid. poke pulses start mid-load.
  task automatic send_img(input int mode, input bit poke);
    int i, budget;
    logic v, acc;
    i = 0;
    budget = 0;
    while (i < img.size() && budget < 20000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (budget % 2) == 0;
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus_if.s_valid = v;
      bus_if.s_data  = v ? img[i] : 8'($urandom);
      start = (poke && i == 2) ? 1'b1 : 1'b0;
      @(negedge clk);
      acc = v && (bus_if.s_ready === 1'b1);
      @(posedge clk); #1;
      if (acc) i++;
      budget++;
    end
    bus_if.s_valid = 1'b0;
    start = 1'b0;
    chk("send_progress", 32'(i), 32'(img.size()));
  endtask

  task automatic wait_end(output int dcyc);
    int n;
    n = 0;
    dcyc = 0;
    while (n < 100) begin
      @(negedge clk);
      if (done === 1'b1 || err === 1'b1) begin
        dcyc = cyc;
        break;
      end
      n++;
    end
    chk("end_reached", 32'(done | err), 32'd1);
  endtask

  task automatic run_case(input int count, input int mode, input bit poke,
                          input bit exp_err, input int exp_wr);
    int base, dcyc, nw;
    bit legal;
    img.delete();
    img.push_back(8'(count));
    img.push_back(8'(count >> 8));
    legal = (count <= DEPTH);
    if (legal) begin
      for (int k = 0; k < count * 4; k++) img.push_back(8'($urandom));
      add_csum();
    end
    base = w_addr.size();
    do_start();
    send_img(mode, poke);
    wait_end(dcyc);
    chk("case_err", 32'(err), 32'(exp_err));
    chk("case_done", 32'(done), 32'(!exp_err));
    chk("case_cpu_rst_n", 32'(cpu_rst_n), 32'(!exp_err));
    nw = w_addr.size() - base;
    chk("case_nwrites", 32'(nw), 32'(exp_wr));
    for (int j = 0; j < nw && j < count && legal; j++) begin
      chk("case_addr", w_addr[base+j], 32'(4 * j));
      chk("case_data", w_data[base+j], model_word(j));
    end
  endtask

  task automatic run_fixed(input int mode);
    int base, dcyc;
    img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    add_csum();
    base = w_addr.size();
    do_start();
    send_img(mode, 1'b0);
`ifndef INST_LOADER_CSUM_EN
    @(negedge clk);
    chk("we_latency", 32'(bus_if.im_we), 32'd1);
`endif
    wait_end(dcyc);
`ifndef INST_LOADER_CSUM_EN
    chk("done_latency", 32'(dcyc - last_we_cyc), 32'd1);
`endif
    chk("fix_done", 32'(done), 32'd1);
    chk("fix_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    chk("fix_nwrites", 32'(w_addr.size() - base), 32'd2);
    if (w_addr.size() - base >= 2) begin
      chk("fix_addr0", w_addr[base], 32'h0000_0000);
      chk("fix_data0", w_data[base], 32'h0010_0513);
      chk("fix_addr1", w_addr[base+1], 32'h0000_0004);
      chk("fix_data1", w_data[base+1], 32'h0020_0593);
    end
  endtask

  typedef struct {
    int count;
    int mode;
    bit poke;
    bit exp_err;
    int exp_wr;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int base, dcyc, rdy_seen, rel_seen, cnt;
    tbl[0] = '{2, 0, 1'b0, 1'b0, 2};
    tbl[1] = '{0, 0, 1'b0, 1'b0, 0};
    tbl[2] = '{1025, 0, 1'b0, 1'b1, 0};
    tbl[3] = '{3, 1, 1'b0, 1'b0, 3};
    tbl[4] = '{DEPTH, 0, 1'b0, 1'b0, DEPTH};
    tbl[5] = '{65535, 2, 1'b0, 1'b1, 0};
    tbl[6] = '{5, 2, 1'b1, 1'b0, 5};
    tbl[7] = '{1, 1, 1'b0, 1'b0, 1};

    rst = 1'b1;
    start = 1'b0;
    bus_if.s_valid = 1'b0;
    bus_if.s_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, then 100 idle cycles with a byte offered but no start.
    @(negedge clk);
    chk("rst_s_ready", 32'(bus_if.s_ready), 32'd0);
    chk("rst_im_we", 32'(bus_if.im_we), 32'd0);
    chk("rst_im_addr", bus_if.im_addr, 32'h0000_0000);
    chk("rst_im_wdata", bus_if.im_wdata, 32'h0000_0000);
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    bus_if.s_valid = 1'b1;
    bus_if.s_data = 8'h5A;
    rdy_seen = 0;
    rel_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus_if.s_ready !== 1'b0) rdy_seen++;
      if (cpu_rst_n !== 1'b0) rel_seen++;
    end
    bus_if.s_valid = 1'b0;
    chk("idle_s_ready", 32'(rdy_seen), 32'd0);
    chk("idle_cpu_rst_n", 32'(rel_seen), 32'd0);
    chk("idle_writes", 32'(w_addr.size()), 32'd0);
    @(posedge clk); #1;

    // Reference image, held valid then toggling valid.
    run_fixed(0);
    run_fixed(1);

    // Restart from DONE drops cpu_rst_n together with the state change.
    do_start();
    @(negedge clk);
    chk("restart_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    img = '{8'h00, 8'h00};
    add_csum();
    send_img(0, 1'b0);
    wait_end(dcyc);
    chk("restart_zero_done", 32'(done), 32'd1);

    // Scenario table.
    for (int t = 0; t < 8; t++)
      run_case(tbl[t].count, tbl[t].mode, tbl[t].poke, tbl[t].exp_err, tbl[t].exp_wr);

    // Random images against the model.
    for (int r = 0; r < 8; r++) begin
      cnt = $urandom_range(0, 9);
      run_case(cnt, $urandom_range(0, 2), 1'($urandom_range(0, 1)), cnt > DEPTH, cnt);
    end

    // Reset in the middle of a word: no write, back to idle.
    img = '{8'h01, 8'h00, 8'h11, 8'h22};
    base = w_addr.size();
    do_start();
    send_img(0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_s_ready", 32'(bus_if.s_ready), 32'd0);
    chk("midrst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("midrst_im_addr", bus_if.im_addr, 32'h0000_0000);
    repeat (10) @(negedge clk);
    chk("midrst_writes", 32'(w_addr.size() - base), 32'd0);
    @(posedge clk); #1;
    img = '{8'h00, 8'h00};
    add_csum();
    do_start();
    send_img(0, 1'b0);
    wait_end(dcyc);
    chk("midrst_zero_done", 32'(done), 32'd1);
    chk("midrst_zero_writes", 32'(w_addr.size() - base), 32'd0);

`ifdef INST_LOADER_CSUM_EN
    // Checksum accepted, then rejected.
    img = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    do_start();
    send_img(0, 1'b0);
    wait_end(dcyc);
    chk("csum_ok_done", 32'(done), 32'd1);
    chk("csum_ok_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    img = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01};
    base = w_addr.size();
    do_start();
    send_img(0, 1'b0);
    wait_end(dcyc);
    chk("csum_bad_err", 32'(err), 32'd1);
    chk("csum_bad_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("csum_bad_writes", 32'(w_addr.size() - base), 32'd1);
`endif

    chk("we_only_in_write", 32'(bad_we), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Writer side of the instruction-memory read path: receives a byte stream, assembles little-endian 32-bit instruction words and writes them into the instruction RAM that the fetch path reads through cur_pc.
- Holds the CPU core in reset (cpu_rst_n low) until a complete, valid image has been written.
- Sits between a byte source (UART receiver or test harness) and the instruction RAM write port.

Parameters:
- ADDR_W, 10, word-address width of instruction RAM; DEPTH = 2^ADDR_W words.
- BASE_ADDR, 32'h0000_0000, byte address of the first written word (word-aligned).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse; begins a load; honoured only in IDLE, DONE or ERR.
- s_data  input  8  stream byte.
- s_valid  input  1  s_data valid.
- s_ready  output  1  loader accepts a byte; transfer occurs when s_valid & s_ready on a clk edge.
- im_we  output  1  instruction RAM write enable, one-cycle pulse per word.
- im_addr  output  32  byte address of the word being written (word-aligned, same convention as cur_pc).
- im_wdata  output  32  assembled instruction word.
- cpu_rst_n  output  1  active-low reset to the CPU core.
- busy  output  1  high in LEN0, LEN1, DATA, WRITE (and CSUM when the optional feature is enabled).
- done  output  1  high in DONE.
- err  output  1  high in ERR.

Behaviour:
- One clock domain; reset is synchronous and active-high (clk, rst).
- Reset state is IDLE. Reset values: s_ready=0, im_we=0, im_addr=BASE_ADDR, im_wdata=0, cpu_rst_n=0, busy=0, done=0, err=0, word count=0, byte index=0.
- Stream format: LEN0 (count[7:0]), LEN1 (count[15:8]), then count×4 data bytes, LSB first per word.
- States:
  - IDLE: s_ready=0. On start -> LEN0; clear address to BASE_ADDR and byte index to 0.
  - LEN0: s_ready=1. On accept, latch the low count byte -> LEN1.
  - LEN1: s_ready=1. On accept, latch the high byte, then:
    - count==0 -> DONE.
    - count>DEPTH -> ERR.
    - otherwise -> DATA.
  - DATA: s_ready=1. Each accepted byte is placed at lane byte index (0..3) of the word register and the index increments. On the 4th byte the index wraps to 0 -> WRITE.
  - WRITE: exactly one cycle; s_ready=0, im_we=1, im_addr and im_wdata stable.
    - Next cycle: im_addr += 4 and remaining words decrement.
    - Remaining==0 -> DONE, otherwise -> DATA.
  - DONE: done=1, cpu_rst_n=1. On start -> LEN0, with cpu_rst_n returning to 0 in the same cycle as the state change.
  - ERR: err=1, cpu_rst_n=0. Stays in ERR until start (-> LEN0) or rst.
- Latency: im_we rises in the cycle immediately after the edge that accepts the 4th byte of a word. cpu_rst_n rises the cycle after the final WRITE.
- s_valid while s_ready=0: no byte is consumed; the source must hold the byte.
- start while busy: ignored.
- rst mid-load: returns to IDLE immediately with the reset values above. No partial word is written. cpu_rst_n=0.
- count==DEPTH is legal; the last word is written at BASE_ADDR+4*(DEPTH-1). The address never wraps.
- im_wdata holds its last value outside WRITE.
- im_we is never asserted outside WRITE.

Optional Feature:
- Macro: INST_LOADER_CSUM_EN.
- Defined: after the last WRITE the FSM enters CSUM (s_ready=1) and accepts one byte. That byte is compared with the XOR of all data bytes; the running XOR is cleared on start.
  - Match -> DONE.
  - Mismatch -> ERR.
  - For count==0, CSUM expects 8'h00.
  - Words are already written on mismatch, but cpu_rst_n stays 0.
- Undefined: no CSUM state; the last WRITE goes directly to DONE; the XOR register is not built.

Test Plan:
- Reset, then no start -> s_ready=0, cpu_rst_n=0, im_we never asserted for 100 cycles.
- start, then bytes 02 00 13 05 10 00 93 05 20 00 with s_valid held high:
  - im_we pulse with addr 0x0, data 0x00100513.
  - im_we pulse with addr 0x4, data 0x00200593.
  - done=1 and cpu_rst_n=1 one cycle after the second write.
- Same image with s_valid toggling 1/0 every cycle, plus s_valid=1 held during WRITE -> identical writes; no byte lost or duplicated.
- Length bytes 01 04 (count 1025) with ADDR_W=10 -> ERR, err=1, no im_we, cpu_rst_n=0; a following start with a valid image recovers to DONE.
- rst asserted after 2 of 4 data bytes -> IDLE next cycle, no write.
  - Then start with 00 00 -> DONE with zero writes.
- (INST_LOADER_CSUM_EN) image 01 00 AA BB CC DD:
  - checksum byte 00 -> DONE.
  - checksum byte 01 -> ERR with cpu_rst_n=0.
